sram_tile_reader: RTL and testbench
===================================

Name: sram_tile_reader

Overview:
- Read-side sequencer for one 4096 x 128-bit activation/weight SRAM bank (registered read port, 1-cycle latency).
- On `start`, it walks `count` addresses from `base_addr` with a fixed `stride` (modulo 4096) and issues one read per word.
- It buffers the returned words and streams them to the PE-array feeder over a valid/ready interface with backpressure.
- Sits between the NPU layer controller (start/busy/done) and the bank's port B.

Parameters:
- ADDR_W, 12, SRAM word-address width; the address space is 2^ADDR_W words.
- DATA_W, 128, SRAM/stream word width.
- LEN_W, 13, width of `count`; must hold 2^ADDR_W.
- FIFO_DEPTH, 4, output buffer entries; must be ≥3 for full throughput and ≥2 for function.

Ports:
- clk  in  1  single clock; SRAM port B clock is tied to this.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command strobe; accepted only in IDLE.
- base_addr  in  ADDR_W  first word address; sampled with start.
- stride  in  ADDR_W  address increment per word; sampled with start.
- count  in  LEN_W  number of words to read; sampled with start; 0 is legal.
- busy  out  1  high while a command is in progress.
- done  out  1  one-cycle completion pulse.
- sram_enb  out  1  SRAM read enable.
- sram_addrb  out  ADDR_W  SRAM read address.
- sram_doutb  in  DATA_W  SRAM read data, valid the cycle after sram_enb.
- m_valid  out  1  stream data valid.
- m_data  out  DATA_W  stream data.
- m_last  out  1  marks the final word of the command.
- m_ready  in  1  stream consumer ready.

Behaviour:
- **Reset (rst=1 at posedge):**
  - State = IDLE.
  - busy, done, sram_enb, m_valid and m_last = 0; sram_addrb and m_data = 0.
  - FIFO cleared, in-flight flag cleared, counters cleared.
  - A read already issued before reset is discarded; its data never reaches the FIFO.
- **States:** IDLE, RUN, DRAIN.
- **IDLE:**
  - start=1 latches base_addr, stride and count.
  - count≠0 → RUN, busy=1 from the next cycle.
  - count=0 → done=1 for exactly the next cycle, busy stays 0, no SRAM access.
- **RUN:**
  - Issue rule: sram_enb=1 iff issued<count AND fifo_count+inflight<FIFO_DEPTH (all registered terms; no combinational path from m_ready).
  - Address of the k-th read (k from 0) = (base + k*stride) mod 2^ADDR_W. Computed by accumulation with truncation to ADDR_W.
  - inflight = registered copy of sram_enb. When inflight=1, sram_doutb is pushed into the FIFO that cycle.
  - First sram_enb occurs the cycle after start; the word appears in the FIFO two cycles after start. With m_ready=1 held, m_valid first rises 3 cycles after the start cycle, then one word per cycle with no bubbles.
  - When issued==count → DRAIN.
- **DRAIN:**
  - No new reads.
  - Exits when the handshake (m_valid & m_ready) with m_last=1 occurs.
  - The next cycle: state=IDLE, busy=0, done=1 (one cycle).
- **Stream rules:**
  - m_valid = FIFO non-empty; m_data = FIFO head.
  - m_data and m_last are held stable while m_valid=1 and m_ready=0.
  - A pop occurs only on m_valid & m_ready. A push and a pop in the same cycle are both honoured.
  - m_last=1 only on the word whose index = count-1.
  - Word order equals address order.
- **Counters:** issued and popped are LEN_W bits.
  - count=2^ADDR_W is legal; addresses wrap and every address is read once when stride is odd.
- **start while busy:** ignored, with no effect on latched parameters.
- **Overflow/underflow:** the FIFO never overflows by construction; an assertion in the bench checks this.

Test Plan:
1. Preload ram[a]=a. base=0x010, stride=1, count=4, m_ready=1. Required response:
   - sram_enb high for exactly 4 consecutive cycles starting 1 cycle after start, with addresses 0x010..0x013.
   - m_data 0x10, 0x11, 0x12, 0x13 on 4 consecutive cycles, m_last on 0x13.
   - done pulses once the cycle after the last beat.
2. base=0xFFE, stride=1, count=4. Required response: addresses 0xFFE, 0xFFF, 0x000, 0x001; data matches; no X on sram_addrb.
3. base=0x005, stride=0x100, count=3. Required response: addresses 0x005, 0x105, 0x205; m_last on the third beat.
4. count=16, with m_ready low for 10 cycles after the first m_valid. Required response:
   - m_data stays constant while stalled.
   - No more than FIFO_DEPTH words are buffered or in flight (sram_enb stops).
   - After release, all 16 words arrive in order with none lost or duplicated.
5. count=0. Required response: done=1 the cycle after start, busy stays 0, sram_enb and m_valid never asserted.
6. Reset and restart:
   - Assert rst for 1 cycle after 2 beats of a count=8 command. Required response: all outputs 0 the next cycle, and no stale beat appears afterwards.
   - New start with count=2. Required response: exactly 2 correct beats, then done.
   - start pulsed during busy. Required response: the pulse is ignored.

Source files
------------

// File: rtl/sram_tile_reader.sv
// Read sequencer for one SRAM bank: walks a strided address range, buffers the
// 1-cycle-latency read data and streams it out over valid/ready.
module sram_tile_reader #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 128,
  parameter int LEN_W      = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] stride,
  input  logic [LEN_W-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              sram_enb,
  output logic [ADDR_W-1:0] sram_addrb,
  input  logic [DATA_W-1:0] sram_doutb,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int CW1 = CW + 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
  localparam logic [CW:0]   DEPTH_C  = CW1'(FIFO_DEPTH);

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] stride_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [LEN_W-1:0]  issued;
  logic [LEN_W-1:0]  popped;
  logic              inflight;
  logic              done_q;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     fcount;
  logic [CW:0]       occ;
  logic              push;
  logic              pop;

  // Occupancy counts the read still on the SRAM pipe, so the buffer can never overflow.
  always_comb begin
    occ        = {1'b0, fcount} + {{CW{1'b0}}, inflight};
    busy       = (state != IDLE);
    done       = done_q;
    sram_enb   = (state == RUN) && (issued < cnt_q) && (occ < DEPTH_C);
    sram_addrb = addr_q;
    m_valid    = (fcount != '0);
    m_data     = m_valid ? mem[rd_ptr] : '0;
    m_last     = m_valid && (popped == cnt_q - LEN_W'(1));
    push       = inflight;
    pop        = m_valid && m_ready;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sram_doutb;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      cnt_q    <= '0;
      issued   <= '0;
      popped   <= '0;
      inflight <= 1'b0;
      done_q   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fcount   <= '0;
    end else begin
      inflight <= sram_enb;
      done_q   <= 1'b0;

      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
        popped <= popped + LEN_W'(1);
      end
      case ({push, pop})
        2'b10:   fcount <= fcount + CW'(1);
        2'b01:   fcount <= fcount - CW'(1);
        default: fcount <= fcount;
      endcase

      if (sram_enb) begin
        addr_q <= addr_q + stride_q;
        issued <= issued + LEN_W'(1);
      end

      case (state)
        IDLE: begin
          if (start) begin
            addr_q   <= base_addr;
            stride_q <= stride;
            cnt_q    <= count;
            issued   <= '0;
            popped   <= '0;
            if (count == '0) done_q <= 1'b1;
            else             state  <= RUN;
          end
        end
        RUN: begin
          if (pop && m_last) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end else if (issued == cnt_q) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && m_last) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_tile_reader.sv
// Directed bench for sram_tile_reader: table of commands plus reset/restart sequence.
module tb_sram_tile_reader;
  localparam int ADDR_W = 12, DATA_W = 128, LEN_W = 13, FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst, start, m_ready;
  logic [ADDR_W-1:0] base_addr, stride, sram_addrb;
  logic [LEN_W-1:0]  count;
  logic              busy, done, sram_enb, m_valid, m_last;
  logic [DATA_W-1:0] sram_doutb, m_data;

  int errors = 0;
  int checks = 0;

  sram_tile_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .stride(stride), .count(count),
    .busy(busy), .done(done), .sram_enb(sram_enb), .sram_addrb(sram_addrb), .sram_doutb(sram_doutb),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] word(input logic [ADDR_W-1:0] a);
    return {4{20'h0, a}};
  endfunction

  // Registered-read SRAM; junk when not enabled so unrequested pushes are visible.
  always @(posedge clk) sram_doutb <= sram_enb ? word(sram_addrb) : {4{32'hDEADBEEF}};

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] stride;
    logic [LEN_W-1:0]  cnt;
    int                stall;
    bit                poke;
    logic [ADDR_W-1:0] exp_last;
  } vec_t;

  task automatic run_cmd(input vec_t v);
    logic [ADDR_W-1:0] exp_addr, last_addr;
    logic [DATA_W-1:0] held;
    int n_iss = 0, n_pop = 0, first_enb = -1, first_valid = -1, last_beat = -1, done_cyc = -1;
    int max_occ = 0, stall_left = 0, limit;
    bit stalled_prev = 0, busy_bad = 0;
    last_addr = '0;
    held = '0;
    limit = int'(v.cnt) + v.stall + 60;
    @(posedge clk); #1;
    start = 1'b1; base_addr = v.base; stride = v.stride; count = v.cnt; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; base_addr = 12'h3C3; stride = 12'h0F0; count = 13'd7;
    for (int k = 1; k <= limit && done_cyc < 0; k++) begin
      @(negedge clk);
      if (v.poke && k == 6) begin
        start = 1'b1; base_addr = 12'hABC; stride = 12'h001; count = 13'd1;
      end else if (v.poke && k == 7) begin
        start = 1'b0;
      end
      if (sram_enb) begin
        if (first_enb < 0) first_enb = k;
        exp_addr = v.base + ADDR_W'(n_iss) * v.stride;
        check("addr", sram_addrb, exp_addr);
        last_addr = sram_addrb;
        n_iss++;
      end
      if (n_iss - n_pop > max_occ) max_occ = n_iss - n_pop;
      if (stalled_prev && m_valid) check("hold data", m_data, held);
      if (m_valid && first_valid < 0) begin
        first_valid = k;
        if (v.stall > 0) begin
          m_ready = 1'b0;
          stall_left = v.stall;
        end
      end else if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) m_ready = 1'b1;
      end
      if (m_valid && m_ready) begin
        check("data", m_data, word(v.base + ADDR_W'(n_pop) * v.stride));
        check("last", m_last, (n_pop == int'(v.cnt) - 1));
        last_beat = k;
        n_pop++;
      end
      stalled_prev = m_valid && !m_ready;
      held = m_data;
      if (busy !== ((v.cnt != '0) && !done)) busy_bad = 1;
      if (done) done_cyc = k;
    end
    check("done seen", (done_cyc > 0), 1);
    if (done_cyc < 0) begin
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0; m_ready = 1'b1;
    end
    check("issued", n_iss, v.cnt);
    check("beats", n_pop, v.cnt);
    check("busy", busy_bad, 0);
    check("occupancy bound", (max_occ <= FIFO_DEPTH), 1);
    if (v.cnt != '0) begin
      check("last addr", last_addr, v.exp_last);
      check("first enb cycle", first_enb, 1);
      check("done timing", done_cyc, last_beat + 1);
      if (v.stall == 0) begin
        check("first valid cycle", first_valid, 3);
        check("no bubbles", last_beat - first_valid, int'(v.cnt) - 1);
      end else begin
        check("fifo fill", max_occ, FIFO_DEPTH);
      end
    end else begin
      check("zero-count done", done_cyc, 1);
    end
    @(negedge clk);
    check("done width", {busy, done}, 2'b00);
  endtask

  vec_t vecs[7];
  int   beats;
  bit   stale;

  initial begin
    vecs[0] = '{12'h010, 12'h001, 13'd4,    0,  1'b0, 12'h013};
    vecs[1] = '{12'hFFE, 12'h001, 13'd4,    0,  1'b0, 12'h001};
    vecs[2] = '{12'h005, 12'h100, 13'd3,    0,  1'b0, 12'h205};
    vecs[3] = '{12'h040, 12'h001, 13'd16,   10, 1'b1, 12'h04F};
    vecs[4] = '{12'h000, 12'h001, 13'd0,    0,  1'b0, 12'h000};
    vecs[5] = '{12'h801, 12'h7FF, 13'd3,    0,  1'b0, 12'h7FF};
    vecs[6] = '{12'h123, 12'h005, 13'd4096, 0,  1'b0, 12'h11E};

    rst = 1'b1; start = 1'b0; base_addr = '0; stride = '0; count = '0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset outputs", {busy, done, sram_enb, m_valid, m_last, sram_addrb}, '0);
    check("reset m_data", m_data, '0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_cmd(vecs[i]);

    // Reset in the middle of a count=8 command, after two accepted beats.
    @(posedge clk); #1;
    start = 1'b1; base_addr = 12'h020; stride = 12'h001; count = 13'd8;
    @(posedge clk); #1;
    start = 1'b0;
    beats = 0;
    for (int k = 0; k < 40 && beats < 2; k++) begin
      @(negedge clk);
      if (m_valid && m_ready) beats++;
    end
    check("beats before reset", beats, 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post-reset outputs", {busy, done, sram_enb, m_valid, m_last, sram_addrb}, '0);
    check("post-reset m_data", m_data, '0);
    rst = 1'b0;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (m_valid || done || busy || sram_enb) stale = 1;
    end
    check("no stale activity", stale, 0);

    run_cmd('{12'h0A0, 12'h003, 13'd2, 0, 1'b1, 12'h0A3});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
